alu_exec: RTL and testbench

- Sequential execution front-end for the team's 4-bit ALU operation set (add, sub, shift left/right, and, or, xor, not).
- Accepts one command (opcode plus A and B) over a valid/ready handshake and executes it.
- Returns a registered result with carry and zero flags over a second valid/ready handshake.
- Shifts execute one bit position per cycle, so the block is multi-cycle. It sits between the instruction/control logic and the register file.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_exec_if.sv | 29 ++
 rtl/alu_exec_comb_core.sv | 39 +++
 rtl/alu_exec.sv | 137 +++++++++++++
 tb/tb_alu_exec.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU execution front-end.
// Opcode and FSM encodings used by the top, its core and the bench.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOT = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(alu_op_t op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Command and result handshakes of the ALU execution front-end.
// master drives commands and consumes results; slave is the ALU.
interface alu_exec_if #(
    parameter int WIDTH = alu_pkg::ALU_W
) ();
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_t          in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_carry, out_zero
    );

endinterface

// File: rtl/alu_exec_comb_core.sv
// Single-cycle ALU ops: add, sub, and, or, xor, not.
// Shift opcodes produce zero here; they are stepped by the top.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;

    // Bit WIDTH of the difference is the unsigned borrow.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        unique case (1'b1)
            (i_op == OP_ADD): {o_carry, o_res} = w_sum;
            (i_op == OP_SUB): {o_carry, o_res} = w_dif;
            (i_op == OP_AND): o_res = i_a & i_b;
            (i_op == OP_OR):  o_res = i_a | i_b;
            (i_op == OP_XOR): o_res = i_a ^ i_b;
            (i_op == OP_NOT): o_res = ~i_a;
            default: begin
                o_res   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU front-end: accepts one command, steps shifts one
// bit per cycle and holds a registered result until it is taken.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]  LP_WB = (WIDTH + 1)'(WIDTH);
    localparam logic [CW-1:0]   LP_WK = CW'(WIDTH);
    localparam logic [CW-1:0]   LP_ONE = CW'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;
    logic             r_left;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_zero;
    logic             r_valid;

    logic [CW-1:0]    w_k;
    logic             w_shift;
    logic [WIDTH-1:0] w_core_res;
    logic             w_core_carry;
    logic [WIDTH-1:0] w_sh_res;
    logic             w_sh_out;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .i_op    (bus.in_op),
        .i_a     (bus.in_a),
        .i_b     (bus.in_b),
        .o_res   (w_core_res),
        .o_carry (w_core_carry)
    );

    assign w_shift = is_shift(bus.in_op);
    assign w_k = ({1'b0, bus.in_b} >= LP_WB) ? LP_WK : CW'(bus.in_b);

    always_comb begin
        w_sh_res = '0;
        w_sh_out = 1'b0;
        if (r_left) begin
            {w_sh_out, w_sh_res} = {r_work, 1'b0};
        end else begin
            {w_sh_res, w_sh_out} = {1'b0, r_work};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next = (w_shift && (w_k != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_cnt == LP_ONE) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_left  <= 1'b0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!w_shift) begin
                            r_res   <= w_core_res;
                            r_carry <= w_core_carry;
                            r_zero  <= (w_core_res == '0);
                            r_valid <= 1'b1;
                        end else if (w_k == '0) begin
                            r_res   <= bus.in_a;
                            r_carry <= 1'b0;
                            r_zero  <= (bus.in_a == '0);
                            r_valid <= 1'b1;
                        end else begin
                            r_work <= bus.in_a;
                            r_cnt  <= w_k;
                            r_left <= (bus.in_op == OP_SHL);
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_sh_res;
                    r_cnt  <= r_cnt - LP_ONE;
                    if (r_cnt == LP_ONE) begin
                        r_res   <= w_sh_res;
                        r_carry <= w_sh_out;
                        r_zero  <= (w_sh_res == '0);
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    // Held low while reset is asserted, even though the state is IDLE.
    assign bus.in_ready  = rst_n && (r_state == IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_res   = r_res;
    assign bus.out_carry = r_carry;
    assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with a small random
// back-to-back logic-op run checked against a reference model.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_exec_if #(.WIDTH(4)) bus ();

    alu_exec #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input alu_op_t op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] er, input logic ec,
                          input int elat);
        int lat;
        bus.out_ready = 1'b1;
        check({tag, ".rdy0"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 4'h0;
        bus.in_b     = 4'h0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            check({tag, ".busy"}, bus.in_ready, 0);
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".res"}, {bus.out_res, bus.out_carry, bus.out_zero},
              {er, ec, (er == 4'h0)});
        tick();
        check({tag, ".rel"}, {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        logic [3:0] a, b, er;
        alu_op_t    op;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = OP_ADD;
        bus.in_a     = 4'h0;
        bus.in_b     = 4'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset.out", {bus.out_valid, bus.out_res, bus.out_carry,
              bus.out_zero}, 7'h00);
        check("reset.rdy", bus.in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset.rdy", bus.in_ready, 1);

        run_op("add_9_8",   OP_ADD, 4'd9,    4'd8, 4'd1,    1'b1, 1);
        run_op("sub_3_5",   OP_SUB, 4'd3,    4'd5, 4'd14,   1'b1, 1);
        run_op("sub_5_5",   OP_SUB, 4'd5,    4'd5, 4'd0,    1'b0, 1);
        run_op("shl_b_2",   OP_SHL, 4'b1011, 4'd2, 4'b1100, 1'b0, 3);
        run_op("shr_b_9",   OP_SHR, 4'b1011, 4'd9, 4'd0,    1'b1, 5);
        run_op("shl_6_0",   OP_SHL, 4'd6,    4'd0, 4'd6,    1'b0, 1);
        run_op("shr_1_1",   OP_SHR, 4'd1,    4'd1, 4'd0,    1'b1, 2);
        run_op("shl_9_1",   OP_SHL, 4'd9,    4'd1, 4'd2,    1'b1, 2);
        run_op("and_c_a",   OP_AND, 4'hC,    4'hA, 4'h8,    1'b0, 1);
        run_op("or_5_0",    OP_OR,  4'h5,    4'h0, 4'h5,    1'b0, 1);
        run_op("add_f_1",   OP_ADD, 4'hF,    4'h1, 4'h0,    1'b1, 1);

        // XOR under backpressure with a competing command presented
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_XOR;
        bus.in_a      = 4'hA;
        bus.in_b      = 4'hF;
        tick();
        bus.in_op = OP_ADD;
        bus.in_a  = 4'h1;
        bus.in_b  = 4'h1;
        for (int i = 0; i < 5; i++) begin
            check("bp.hold", {bus.out_valid, bus.out_res, bus.out_carry,
                  bus.out_zero}, {1'b1, 4'h5, 1'b0, 1'b0});
            check("bp.rdy", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        check("bp.last", {bus.out_valid, bus.out_res}, {1'b1, 4'h5});
        tick();
        check("bp.rel", {bus.out_valid, bus.in_ready}, 2'b01);
        tick();
        bus.in_valid = 1'b0;
        check("bp.next", {bus.out_valid, bus.out_res, bus.out_carry},
              {1'b1, 4'h2, 1'b0});
        tick();
        check("bp.next_rel", {bus.out_valid, bus.in_ready}, 2'b01);

        // Reset in the second SHIFT cycle discards the command
        bus.in_valid = 1'b1;
        bus.in_op    = OP_SHR;
        bus.in_a     = 4'hF;
        bus.in_b     = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        check("rst_sh.busy", {bus.out_valid, bus.in_ready}, 2'b00);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_sh.rdy_low", bus.in_ready, 0);
        tick();
        check("rst_sh.out", {bus.out_valid, bus.out_res, bus.out_carry,
              bus.out_zero}, 7'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_sh.quiet", {bus.out_valid, bus.in_ready}, 2'b01);
        end
        run_op("not_0", OP_NOT, 4'h0, 4'h0, 4'hF, 1'b0, 1);

        // Back-to-back AND/OR/NOT: one result every two cycles
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: begin op = OP_AND; er = a & b; end
                1: begin op = OP_OR;  er = a | b; end
                default: begin op = OP_NOT; er = ~a; end
            endcase
            bus.in_valid = 1'b1;
            bus.in_op    = op;
            bus.in_a     = a;
            bus.in_b     = b;
            tick();
            check("rnd.res", {bus.out_valid, bus.in_ready, bus.out_res,
                  bus.out_carry, bus.out_zero},
                  {1'b1, 1'b0, er, 1'b0, (er == 4'h0)});
            tick();
            check("rnd.idle", {bus.out_valid, bus.in_ready}, 2'b01);
        end
        bus.in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
